// File: rtl/binary_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : binary_tx_pkg                                                |
// | Description : Shared definitions for the binary_tx serial pattern          |
// |               transmitter: state width, binary state codes and a helper    |
// |               that picks the state following the data/parity bits.         |
// |               The optional parity feature is enabled by the                |
// |               BINARY_TX_PARITY_EN macro (see binary_tx.sv).                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package binary_tx_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'b000;
    localparam logic [STATE_W-1:0] ST_SHIFT  = 3'b001;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'b010;
    localparam logic [STATE_W-1:0] ST_GAP    = 3'b011;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'b100;

    // After the last payload bit the frame goes to GAP, unless the gap is
    // configured away, in which case DONE follows directly.
    function automatic logic [STATE_W-1:0] post_data_state(input int gap);
        return (gap > 0) ? ST_GAP : ST_DONE;
    endfunction

endpackage : binary_tx_pkg
`default_nettype wire

// File: rtl/binary_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : binary_tx_if                                                 |
// | Description : Handshake/serial bundle of the binary_tx transmitter.        |
// |               master : drives start/pattern, observes the serial side.     |
// |               slave  : the transmitter itself.                             |
// |   start   - request to send (accepted only while ready=1)                  |
// |   pattern - WIDTH-bit parallel data, sampled on acceptance                 |
// |   ready   - high only in IDLE                                              |
// |   w       - serial data to the detector, MSB first                         |
// |   w_valid - high while a data or parity bit is on w                        |
// |   done    - one-cycle pulse at frame end                                   |
// |   State   - current binary-encoded state                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface binary_tx_if
    import binary_tx_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic               start;
    logic [WIDTH-1:0]   pattern;
    logic               ready;
    logic               w;
    logic               w_valid;
    logic               done;
    logic [STATE_W-1:0] State;

    modport master (
        output start,
        output pattern,
        input  ready,
        input  w,
        input  w_valid,
        input  done,
        input  State
    );

    modport slave (
        input  start,
        input  pattern,
        output ready,
        output w,
        output w_valid,
        output done,
        output State
    );

endinterface : binary_tx_if
`default_nettype wire

// File: rtl/binary_tx_piso_shift.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piso_shift                                                   |
// | Description : WIDTH-bit parallel-in / serial-out shift register.           |
// |               load has priority over shift; shifting moves left and fills  |
// |               with 0 so the MSB is always the next bit to send.            |
// |   clk   - rising-edge clock                                                |
// |   clr_n - asynchronous active-low clear                                    |
// |   load  - capture din                                                      |
// |   shift - shift left by one                                                |
// |   din   - parallel input                                                   |
// |   msb   - current most significant bit                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_shreg;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= din;
        end else if (shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_shreg[WIDTH-1];

endmodule : piso_shift
`default_nettype wire

// File: rtl/binary_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : binary_tx                                                    |
// | Description : Serial pattern transmitter feeding the binary-encoded        |
// |               sequence detector. A pattern captured on start&ready is      |
// |               shifted out MSB first on w, optionally followed by a parity  |
// |               bit, then GAP idle cycles and a one-cycle done pulse.        |
// |   clk   - rising-edge clock                                                |
// |   reset - asynchronous active-low reset                                    |
// |   bus   - binary_tx_if.slave (start, pattern, ready, w, w_valid, done,     |
// |           State)                                                           |
// | Parameters : WIDTH (2..32) pattern length, GAP (0..15) idle cycles.        |
// | Option      : BINARY_TX_PARITY_EN adds the PARITY state carrying the XOR   |
// |               of the captured pattern (even parity).                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module binary_tx
    import binary_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic         clk,
    input  logic         reset,
    binary_tx_if.slave   bus
);

    localparam int                 c_cnt_w      = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit   = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    // The gap counter runs GAP-1 .. 0 so GAP cycles are spent in GAP.
    localparam logic [3:0]         c_gap_load   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [STATE_W-1:0] c_after_data = post_data_state(GAP);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic               w_load;
    logic               w_shift;
    logic               w_msb;

    logic               w_ready;
    logic               w_w;
    logic               w_w_valid;
    logic               w_done;

    // ready is only high in IDLE, so start&ready reduces to start in IDLE.
    assign w_load  = (r_state == ST_IDLE) && bus.start;
    assign w_shift = (r_state == ST_SHIFT);

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso_shift (
        .clk   (clk),
        .clr_n (reset),
        .load  (w_load),
        .shift (w_shift),
        .din   (bus.pattern),
        .msb   (w_msb)
    );

`ifdef BINARY_TX_PARITY_EN
    logic r_parity;

    // Parity is taken from the pattern at load so later pattern changes
    // cannot disturb the frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^bus.pattern;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; unused codes fall back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == c_last_bit) begin
`ifdef BINARY_TX_PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_next = c_after_data;
`endif
                end
            end
`ifdef BINARY_TX_PARITY_EN
            ST_PARITY: begin
                w_next = c_after_data;
            end
`endif
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bit and gap counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_gap_cnt <= 4'd0;
        end else begin
            if (w_load) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + c_cnt_one;
            end

            if ((r_state != ST_GAP) && (w_next == ST_GAP)) begin
                r_gap_cnt <= c_gap_load;
            end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        w_ready   = 1'b0;
        w_w       = 1'b0;
        w_w_valid = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_SHIFT: begin
                w_w       = w_msb;
                w_w_valid = 1'b1;
            end
`ifdef BINARY_TX_PARITY_EN
            ST_PARITY: begin
                w_w       = r_parity;
                w_w_valid = 1'b1;
            end
`endif
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    assign bus.ready   = w_ready;
    assign bus.w       = w_w;
    assign bus.w_valid = w_w_valid;
    assign bus.done    = w_done;
    assign bus.State   = r_state;

endmodule : binary_tx
`default_nettype wire

// File: tb/tb_binary_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_binary_tx                                                 |
// | Description : Self-checking bench for binary_tx (WIDTH=8, GAP=2, plus a    |
// |               GAP=0 instance sharing the same inputs). Expected per-cycle  |
// |               outputs come from a frame queue built from the pattern.      |
// |               Honours BINARY_TX_PARITY_EN.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_binary_tx;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
`ifdef BINARY_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = WIDTH + PAR + GAP + 1;
    localparam int PERIOD    = 1 + WIDTH + PAR + GAP + 1;
    localparam int PERIOD0   = 1 + WIDTH + PAR + 0 + 1;

    typedef struct packed {
        logic       ready;
        logic       w;
        logic       wv;
        logic       done;
        logic [2:0] st;
    } obs_t;

    typedef struct {
        logic [WIDTH-1:0] pat;
        logic [WIDTH-1:0] exp_ser;
        logic             exp_par;
        int               glitch;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] pattern;

    always #5 clk = ~clk;

    binary_tx_if #(.WIDTH(WIDTH)) bus  ();
    binary_tx_if #(.WIDTH(WIDTH)) bus0 ();

    assign bus.start    = start;
    assign bus.pattern  = pattern;
    assign bus0.start   = start;
    assign bus0.pattern = pattern;

    binary_tx #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    binary_tx #(.WIDTH(WIDTH), .GAP(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t q[$];
    obs_t s_obs;
    obs_t s0_obs;

    function automatic obs_t mk(logic r, logic w, logic v, logic d, logic [2:0] st);
        obs_t o;
        o.ready = r;
        o.w     = w;
        o.wv    = v;
        o.done  = d;
        o.st    = st;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    endfunction

    function automatic obs_t dut_obs();
        return {bus.ready, bus.w, bus.w_valid, bus.done, bus.State};
    endfunction

    function automatic obs_t dut0_obs();
        return {bus0.ready, bus0.w, bus0.w_valid, bus0.done, bus0.State};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole frame as the receiver should see it, one entry per cycle.
    task automatic push_frame(input logic [WIDTH-1:0] pat);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            q.push_back(mk(1'b0, pat[i], 1'b1, 1'b0, 3'd1));
        end
        if (PAR == 1) begin
            q.push_back(mk(1'b0, 1'(($countones(pat)) % 2), 1'b1, 1'b0, 3'd2));
        end
        for (int i = 0; i < GAP; i++) begin
            q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
    endtask

    // Compare on the falling edge, advance the model on the rising edge,
    // then leave 1 time unit before the caller drives new inputs.
    task automatic tick();
        @(negedge clk);
        s_obs  = dut_obs();
        s0_obs = dut0_obs();
        check("outputs{ready,w,w_valid,done,State}", 32'(s_obs),
              32'((q.size() != 0) ? q[0] : idle_obs()));
        @(posedge clk);
        if (!reset) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (start) push_frame(pattern);
        end else begin
            void'(q.pop_front());
        end
        #1;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] pat, input int glitch,
                              output logic [WIDTH-1:0] ser, output logic par,
                              output int ndone, output int len);
        int nbits;
        nbits = 0;
        ser   = '0;
        par   = 1'b0;
        ndone = 0;
        len   = 0;
        start   = 1'b1;
        pattern = pat;
        tick();
        for (int k = 0; k < 60; k++) begin
            start   = (k == glitch);
            pattern = WIDTH'($urandom);
            tick();
            len++;
            if (s_obs.wv) begin
                if (nbits < WIDTH) ser = {ser[WIDTH-2:0], s_obs.w};
                else               par = s_obs.w;
                nbits++;
            end
            if (s_obs.done) begin
                ndone++;
                break;
            end
        end
        start = 1'b0;
        repeat (2) begin
            tick();
            if (s_obs.done) ndone++;
        end
    endtask

    vec_t             tbl[6];
    logic [WIDTH-1:0] ser;
    logic             par;
    int               ndone;
    int               len;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'b1011_0010, 8'b1011_0010, 1'b0, -1};
        tbl[1] = '{8'h01,        8'h01,        1'b1, -1};
        tbl[2] = '{8'hFF,        8'hFF,        1'b0, -1};
        tbl[3] = '{8'h00,        8'h00,        1'b0, -1};
        tbl[4] = '{8'h80,        8'h80,        1'b1,  3};
        tbl[5] = '{8'h5A,        8'h5A,        1'b0,  5};

        reset   = 1'b0;
        start   = 1'b0;
        pattern = '0;
        #2;
        check("reset_state", 32'(dut_obs()), 32'(idle_obs()));
        check("reset_state_gap0", 32'(dut0_obs()), 32'(idle_obs()));
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Table of single frames, some with a start pulse during SHIFT.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].pat, tbl[i].glitch, ser, par, ndone, len);
            check($sformatf("serial_bits[%0d]", i), 32'(ser), 32'(tbl[i].exp_ser));
`ifdef BINARY_TX_PARITY_EN
            check($sformatf("parity_bit[%0d]", i), 32'(par), 32'(tbl[i].exp_par));
`endif
            check($sformatf("done_pulses[%0d]", i), ndone, 1);
            check($sformatf("frame_len[%0d]", i), len, FRAME_LEN);
        end

        // Asynchronous reset after three bits of a frame.
        start   = 1'b1;
        pattern = 8'hC3;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 32'(dut_obs()), 32'(idle_obs()));
        q.delete();
        tick();
        check("no_done_after_abort", 32'(s_obs.done), 0);
        reset = 1'b1;
        send_frame(8'b1110_0101, -1, ser, par, ndone, len);
        check("post_reset_serial", 32'(ser), 32'(8'b1110_0101));
        check("post_reset_done", ndone, 1);

        // start held high: back-to-back frames on both GAP settings.
        begin
            int d_t[$];
            int d0_t[$];
            logic saw_gap0;
            saw_gap0 = 1'b0;
            start    = 1'b1;
            pattern  = 8'hFF;
            for (int t = 0; t < 60; t++) begin
                tick();
                if (s_obs.done)        d_t.push_back(t);
                if (s0_obs.done)       d0_t.push_back(t);
                if (s0_obs.st == 3'd3) saw_gap0 = 1'b1;
            end
            start = 1'b0;
            repeat (20) tick();
            check("hold_done_count", 32'(d_t.size() >= 4), 1);
            check("hold_done_count_gap0", 32'(d0_t.size() >= 5), 1);
            for (int i = 1; i < d_t.size(); i++)
                check($sformatf("hold_period[%0d]", i), d_t[i] - d_t[i-1], PERIOD);
            for (int i = 1; i < d0_t.size(); i++)
                check($sformatf("hold_period_gap0[%0d]", i), d0_t[i] - d0_t[i-1], PERIOD0);
            check("gap0_never_in_gap", 32'(saw_gap0), 0);
        end

        // Random start/pattern traffic against the frame model.
        for (int t = 0; t < 400; t++) begin
            start   = ($urandom_range(0, 9) < 3);
            pattern = WIDTH'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_binary_tx
`default_nettype wire
